// File: rtl/pgm_palette_out.sv
// PGM palette output stage: dual-port RGB555 palette RAM (video read / 68000 access)
// feeding a fixed two-clock colour pipeline with syncs re-aligned to the colour data.
module pgm_palette_out #(
  parameter int IDX_W = 12,
  parameter int DEPTH = 2304,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             blank_n_in,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [IDX_W-1:0] cpu_addr,
  input  logic [1:0]       cpu_be,
  input  logic [15:0]      cpu_din,
  output logic [15:0]      cpu_dout,
  output logic             cpu_ack,
  output logic             hs,
  output logic             vs,
  output logic             blank_n,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b
);

  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);

  generate
    if (LAT != 2) begin : g_lat_check
      $error("pgm_palette_out: the video pipeline latency is fixed at 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2,
    S_WAIT   = 2'd3
  } cpu_state_t;

  function automatic logic [7:0] expand5(input logic [4:0] c5);
    return {c5, c5[4:2]};
  endfunction

  logic [15:0] r_mem [DEPTH];

  logic             w_vid_oor;
  logic [IDX_W-1:0] w_vid_addr;

  logic [14:0] r_word_p1;
  logic        r_hs_p1;
  logic        r_vs_p1;
  logic        r_blank_p1;
  logic        r_oor_p1;

  logic [7:0]  r_r_p2;
  logic [7:0]  r_g_p2;
  logic [7:0]  r_b_p2;
  logic        r_hs_p2;
  logic        r_vs_p2;
  logic        r_blank_p2;
  logic        w_black_p1;

  cpu_state_t       r_state;
  cpu_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_cpu_addr;
  logic             r_cpu_we;
  logic [1:0]       r_cpu_be;
  logic [15:0]      r_cpu_din;
  logic             r_cpu_ack;
  logic [15:0]      r_cpu_dout;
  logic             w_cpu_oor;
  logic [IDX_W-1:0] w_cpu_addr;
  logic             w_wr_en;

  // Out-of-range indices are steered to entry 0 so the array is never indexed past its end;
  // the registered flag blanks the pixel instead.
  assign w_vid_oor  = (pix_idx >= DEPTH_L);
  assign w_vid_addr = w_vid_oor ? '0 : pix_idx;

  // ---- stage 1: palette read, syncs and range flag registered ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_p1  <= '0;
      r_hs_p1    <= 1'b1;
      r_vs_p1    <= 1'b1;
      r_blank_p1 <= 1'b0;
      r_oor_p1   <= 1'b0;
    end else begin
      r_word_p1  <= r_mem[w_vid_addr][14:0];
      r_hs_p1    <= hs_in;
      r_vs_p1    <= vs_in;
      r_blank_p1 <= blank_n_in;
      r_oor_p1   <= w_vid_oor;
    end
  end

  assign w_black_p1 = !r_blank_p1 || r_oor_p1;

  // ---- stage 2: colour expansion and black forcing ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r_p2     <= '0;
      r_g_p2     <= '0;
      r_b_p2     <= '0;
      r_hs_p2    <= 1'b1;
      r_vs_p2    <= 1'b1;
      r_blank_p2 <= 1'b0;
    end else begin
      r_r_p2     <= w_black_p1 ? 8'h00 : expand5(r_word_p1[14:10]);
      r_g_p2     <= w_black_p1 ? 8'h00 : expand5(r_word_p1[9:5]);
      r_b_p2     <= w_black_p1 ? 8'h00 : expand5(r_word_p1[4:0]);
      r_hs_p2    <= r_hs_p1;
      r_vs_p2    <= r_vs_p1;
      r_blank_p2 <= r_blank_p1;
    end
  end

  assign r       = r_r_p2;
  assign g       = r_g_p2;
  assign b       = r_b_p2;
  assign hs      = r_hs_p2;
  assign vs      = r_vs_p2;
  assign blank_n = r_blank_p2;

  assign w_cpu_oor  = (r_cpu_addr >= DEPTH_L);
  assign w_cpu_addr = w_cpu_oor ? '0 : r_cpu_addr;
  assign w_wr_en    = (r_state == S_ACCESS) && r_cpu_we && !w_cpu_oor;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cpu_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_WAIT;
      S_WAIT:   if (!cpu_req) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The FSM resets asynchronously, so an access interrupted by reset never reaches the
  // write edge: the word is either written whole or not touched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cpu_addr <= '0;
      r_cpu_we   <= 1'b0;
      r_cpu_be   <= 2'b00;
      r_cpu_din  <= '0;
      r_cpu_ack  <= 1'b0;
      r_cpu_dout <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_ack <= (w_state_nxt == S_ACK);
      if (r_state == S_IDLE && cpu_req) begin
        r_cpu_addr <= cpu_addr;
        r_cpu_we   <= cpu_we;
        r_cpu_be   <= cpu_be;
        r_cpu_din  <= cpu_din;
      end
      if (r_state == S_ACCESS && !r_cpu_we) begin
        r_cpu_dout <= w_cpu_oor ? 16'h0000 : r_mem[w_cpu_addr];
      end
    end
  end

  // Palette contents survive reset; the video read above samples the old word on a
  // same-address collision because both sides update on the same edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_cpu_be[1]) r_mem[w_cpu_addr][15:8] <= r_cpu_din[15:8];
      if (r_cpu_be[0]) r_mem[w_cpu_addr][7:0]  <= r_cpu_din[7:0];
    end
  end

  assign cpu_ack  = r_cpu_ack;
  assign cpu_dout = r_cpu_dout;

endmodule
